// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period default
// used by both the transmitter and the receiver.
`timescale 1ns/1ps
package uart_pkg;

  // 27 MHz / 115200 baud, rounded.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 234;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter, so idle-high and idle-low lines both start clean.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments, so both flops sample
  // their inputs before either updates and the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised RX pin, LSB first,
// presenting each byte on a valid/ready holding register.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // NOTE: a delivery further down assigns valid_q again; the later
      // non-blocking assignment wins, so consume-and-refill keeps valid high.
      if (valid_q && ready_i) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            if (!rx_s) begin
              state_q   <= DATA;
              cnt_q     <= '0;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
            cnt_q   <= '0;
            if (bit_idx_q == IDX_LAST) state_q <= STOP;
            else                       bit_idx_q <= bit_idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              // Leaving mid-stop-bit gives half a bit to catch a back-to-back start.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || ready_i) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              state_q     <= BREAK;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven at real-valued bit periods, with a
// byte-queue reference of what a correct 8N1 receiver must hand over.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CPB    = 16;
  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CPB * CLK_NS;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  always #(CLK_NS / 2.0) clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: every well-framed byte sent while the consumer can take it,
  // in send order. The monitor records what the DUT actually hands over.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int ferr_cnt    = 0;
  int ovr_cnt     = 0;
  int busy_cycles = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o) ferr_cnt++;
      if (overrun_o)   ovr_cnt++;
      if (busy_o)      busy_cycles++;
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    ferr_cnt    = 0;
    ovr_cnt     = 0;
    busy_cycles = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input real bit_ns);
    rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      #(bit_ns);
    end
    rx_i = stop_val;
    #(bit_ns);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_ferr"}, ferr_cnt, 0);
    check({tag, "_ovr"},  ovr_cnt,  0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},  data_o,      8'h00);
    check({tag, "_valid"}, valid_o,     1'b0);
    check({tag, "_ferr"},  frame_err_o, 1'b0);
    check({tag, "_ovr"},   overrun_o,   1'b0);
    check({tag, "_busy"},  busy_o,      1'b0);
  endtask

  initial begin
    int   lat;
    real  scale;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_busy_after", busy_o, 1'b0);

    // Single byte with latency measurement: cycles with valid low after the pin falls
    clear_mon();
    @(negedge clk);
    fork
      send_byte(8'hA5, 1'b1, BIT_NS);
      begin
        for (lat = 0; lat < 400; lat++) begin
          @(negedge clk);
          if (valid_o) break;
        end
        check("a5_latency", lat, 7 + 9 * CPB + 3);
        check("a5_data", data_o, 8'hA5);
        @(negedge clk);
        check("a5_valid_one_cycle", valid_o, 1'b0);
      end
    join
    #(2 * BIT_NS);
    exp_q.push_back(8'hA5);
    check_stream("single");

    // Glitch shorter than half a bit
    clear_mon();
    @(negedge clk);
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_cycles", busy_cycles, 8);
    check_stream("glitch");

    // Framing error, line held low, then recovery
    clear_mon();
    send_byte(8'h3C, 1'b0, BIT_NS);
    repeat (40) @(negedge clk);
    check("ferr_pulses", ferr_cnt, 1);
    check("ferr_no_byte", got_q.size(), 0);
    check("ferr_busy_in_break", busy_o, 1'b1);
    rx_i = 1'b1;
    #(2 * BIT_NS);
    check("ferr_busy_released", busy_o, 1'b0);
    ferr_cnt = 0;
    send_byte(8'h81, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    exp_q.push_back(8'h81);
    check_stream("ferr_recover");

    // Overrun with the consumer stalled
    clear_mon();
    ready_i = 1'b0;
    send_byte(8'h11, 1'b1, BIT_NS);
    send_byte(8'h22, 1'b1, BIT_NS);
    #(BIT_NS);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_valid", valid_o, 1'b1);
    check("ovr_data_kept", data_o, 8'h11);
    check("ovr_nothing_taken", got_q.size(), 0);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_dropped", valid_o, 1'b0);
    exp_q.push_back(8'h11);
    ovr_cnt = 0;
    check_stream("ovr_drain");

    // Baud tolerance: +3% then -3%, no idle gap between frames
    for (int s = 0; s < 2; s++) begin
      clear_mon();
      scale = (s == 0) ? 1.03 : 0.97;
      send_byte(8'h55, 1'b1, BIT_NS * scale);
      send_byte(8'hAA, 1'b1, BIT_NS * scale);
      send_byte(8'h00, 1'b1, BIT_NS * scale);
      send_byte(8'hFF, 1'b1, BIT_NS * scale);
      #(2 * BIT_NS);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      check_stream((s == 0) ? "baud_slow" : "baud_fast");
    end

    // Random bytes, random idle gaps, small random bit-period error
    clear_mon();
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      scale = real'($urandom_range(98, 102)) / 100.0;
      send_byte(b, 1'b1, BIT_NS * scale);
      exp_q.push_back(b);
      #(CLK_NS * $urandom_range(0, 30));
    end
    #(2 * BIT_NS);
    check_stream("random");

    // Reset in the middle of data bit 4
    clear_mon();
    b = 8'hC3;
    rx_i = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      #(BIT_NS);
    end
    rx_i = b[4];
    #(BIT_NS / 2.0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * BIT_NS);
    check("midreset_no_byte", got_q.size(), 0);
    send_byte(8'h7E, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    exp_q.push_back(8'h7E);
    check_stream("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

Receives 8N1 asynchronous serial bytes on the UART RX pin and presents each byte on a valid/ready output to the command decoder. It is the receive-side counterpart of the existing UART transmitter and uses the same bit-period parameter, so both ends run at one baud rate. It synchronises the pin, checks the start bit at mid-bit, and samples bits LSB-first. Stop-bit failures and bytes lost to back-pressure are flagged.

## Interface
- CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200); minimum 4.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_i  in  1  raw serial input, asynchronous to clk; idles high.
- data_o  out  8  received byte; stable while valid_o=1.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts; transfer occurs when valid_o && ready_i.
- frame_err_o  out  1  one-cycle pulse when the stop bit samples 0.
- overrun_o  out  1  one-cycle pulse when a byte is dropped because the holding register is full.
- busy_o  out  1  high in every state except IDLE.

## Operation
- Input: 2-flop synchroniser gives rx_s. The FSM sees only rx_s.
- Counters:
  - cnt: 0..CLKS_PER_BIT-1.
  - bit_idx: 0..7.
  - H = (CLKS_PER_BIT-1)/2, integer division.
- FSM states:
  - IDLE: rx_s=0 → START, cnt=0.
  - START: when cnt==H, sample rx_s.
    - 0 → DATA, with cnt=0 and bit_idx=0.
    - 1 → IDLE. Glitch rejected, no flag raised.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (right shift, so LSB arrives first) and set cnt=0. After bit_idx==7 → STOP; otherwise bit_idx+1.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1 → deliver the byte, then → IDLE.
    - 0 → pulse frame_err_o, discard the byte, → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. Prevents re-triggering on a held-low line.
- Delivery happens in the STOP-sample cycle:
  - If valid_o==0, or valid_o && ready_i in that same cycle: data_o ← shreg and valid_o=1 on the next edge.
  - Otherwise: data_o is kept, the new byte is dropped, and overrun_o pulses.
- valid_o clears on the edge after valid_o && ready_i, unless a delivery occurs in that same cycle.
- Reset values: every output is 0 (data_o=8'h00, valid_o, frame_err_o, overrun_o, busy_o all 0). State=IDLE, counters 0. Both synchroniser flops reset to 1, so reset release on a low line is treated as a start edge only after real synchronisation.
- Reset asserted mid-frame aborts the frame immediately. The partial byte is lost and no flag is raised.

## Timing
- Pin-to-FSM latency: 2 cycles (synchroniser).
- The start is sampled H cycles after entering START.
- Data bit k is sampled H + (k+1)·CLKS_PER_BIT cycles after entering START.
- The stop bit is sampled H + 9·CLKS_PER_BIT cycles after entering START.
- valid_o, frame_err_o and overrun_o assert on the edge after the stop sample.
- busy_o falls on that same edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, leaving about half a bit of margin to detect the next start edge. Consecutive frames with no idle gap are received without loss.
- ready_i may stay high permanently; each byte is then held for ≥1 cycle and the stream is lossless.

## Structure
- Package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - DEFAULT_CLKS_PER_BIT constant, shared with the transmitter.
  - DATA_BITS=8.
- Sub-module sync_2ff: 2-flop synchroniser with a reset-value parameter, also reusable for other async inputs.
- No other hierarchy.

## Test plan
All scenarios use CLKS_PER_BIT=16 and ready_i=1 unless stated.
- **Single byte:** send 8'hA5 with ideal timing → valid_o high for exactly 1 cycle with data_o=8'hA5, at H+9·16+3=154 cycles after the pin falls (synchroniser latency included). frame_err_o and overrun_o stay 0.
- **Glitch:** drive rx_i low for 5 cycles, then high → returns to IDLE at cnt==7. No valid_o, no flags. busy_o is high for 8 cycles.
- **Framing error:** send 8'h3C with stop bit 0, line held low for 40 more cycles → frame_err_o pulses once, valid_o stays 0. FSM stays in BREAK until the line rises, then 8'h81 is received correctly.
- **Overrun:** ready_i=0, send 8'h11 then 8'h22 back-to-back → data_o=8'h11, valid_o high, overrun_o pulses at the second stop sample. With ready_i=1 afterwards, 8'h11 is consumed and valid_o drops.
- **Baud tolerance:** send 8'h55, 8'hAA, 8'h00, 8'hFF at ±3% bit period with no idle gaps → all four bytes delivered in order with no flags.
- **Reset mid-frame:** assert rst_n low during data bit 4 → all outputs are 0 immediately and state=IDLE. A subsequent 8'h7E is received correctly.
